// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: opcodes, funct3 sizes,
// FSM states and fault codes.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_MIS  = 2'b01;
    localparam logic [1:0] FLT_ILL  = 2'b10;
    localparam logic [1:0] FLT_TMO  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for RV32I loads/stores: store strobes and replicated
// write data, load extraction/extension, and size/alignment checks.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic        misaligned,
    output logic        illegal_size
);

    logic [31:0] shifted;

    always_comb begin
        shifted      = rdata >> {off, 3'b000};
        wstrb        = 4'b0000;
        wdata        = 32'h0;
        load_ext     = 32'h0;
        misaligned   = 1'b0;
        illegal_size = 1'b0;
        unique case (funct3)
            F3_B: begin
                wstrb    = 4'b0001 << off;
                wdata    = {4{store_data[7:0]}};
                load_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                wstrb    = 4'b0001 << off;
                wdata    = {4{store_data[7:0]}};
                load_ext = {24'h0, shifted[7:0]};
            end
            F3_H: begin
                wstrb      = 4'b0011 << off;
                wdata      = {2{store_data[15:0]}};
                load_ext   = {{16{shifted[15]}}, shifted[15:0]};
                misaligned = off[0];
            end
            F3_HU: begin
                wstrb      = 4'b0011 << off;
                wdata      = {2{store_data[15:0]}};
                load_ext   = {16'h0, shifted[15:0]};
                misaligned = off[0];
            end
            F3_W: begin
                wstrb      = 4'b1111;
                wdata      = store_data;
                load_ext   = shifted;
                misaligned = (off != 2'b00);
            end
            default: illegal_size = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one request at a time, checks it,
// runs a req/ack transaction with timeout and returns the extended result.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode_reg,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;

    logic [2:0]        al_f3;
    logic [1:0]        al_off;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load_ext;
    logic              al_mis;
    logic              al_ill_size;
    logic              is_load;
    logic              is_store;
    logic              illegal;

    // One aligner serves both phases: incoming request fields while idle,
    // the latched size/offset while waiting for read data.
    assign al_f3  = (state_q == IDLE) ? funct3     : f3_q;
    assign al_off = (state_q == IDLE) ? addr[1:0]  : off_q;

    lsu_align u_align (
        .funct3       (al_f3),
        .off          (al_off),
        .store_data   (store_data),
        .rdata        (mem_rdata),
        .wstrb        (al_wstrb),
        .wdata        (al_wdata),
        .load_ext     (al_load_ext),
        .misaligned   (al_mis),
        .illegal_size (al_ill_size)
    );

    assign is_load  = (opcode_reg == OPC_LOAD);
    assign is_store = (opcode_reg == OPC_STORE);
    assign illegal  = !(is_load || is_store) || al_ill_size ||
                      (is_store && (funct3 >= 3'b011));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        off_d        = off_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        load_data_d  = load_data_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    f3_d  = funct3;
                    off_d = addr[1:0];
                    cnt_d = '0;
                    if (illegal || al_mis) begin
                        state_d      = DONE;
                        fault_d      = 1'b1;
                        fault_code_d = illegal ? FLT_ILL : FLT_MIS;
                        load_data_d  = 32'h0;
                    end else begin
                        state_d = ACCESS;
                        we_d    = is_store;
                        addr_d  = {addr[31:2], 2'b00};
                        wstrb_d = is_store ? al_wstrb : 4'b0000;
                        wdata_d = is_store ? al_wdata : 32'h0;
                    end
                end
            end
            ACCESS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (mem_ack) begin
                    state_d      = DONE;
                    fault_d      = 1'b0;
                    fault_code_d = FLT_NONE;
                    load_data_d  = we_q ? 32'h0 : al_load_ext;
                end else if (cnt_q == TMO_LAST) begin
                    state_d      = DONE;
                    fault_d      = 1'b1;
                    fault_code_d = FLT_TMO;
                    load_data_d  = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (mem_ack || (cnt_q == TMO_LAST)) begin
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    wdata_d = 32'h0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wstrb_q      <= 4'b0000;
            wdata_q      <= 32'h0;
            load_data_q  <= 32'h0;
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign mem_req    = (state_q == ACCESS);
    assign done       = (state_q == DONE);
    assign load_data  = load_data_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected bus and
// completion records; a negedge monitor pops and compares them.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode_reg;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_reg(opcode_reg), .funct3(funct3), .addr(addr),
        .store_data(store_data), .done(done), .load_data(load_data),
        .fault(fault), .fault_code(fault_code), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic [31:0] ld;
        logic        flt;
        logic [1:0]  code;
        int          at;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [3:0]  strb;
        logic [31:0] wd;
        int          nreq;
    } mem_t;

    resp_t rq[$];
    mem_t  mq[$];
    int    cyc = 0;
    int    req_cnt = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: completion records on done, bus records while mem_req is high.
    always @(negedge clk) begin
        if (done) begin
            if (rq.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                resp_t r;
                r = rq.pop_front();
                chk("load_data", 64'(load_data), 64'(r.ld));
                chk("fault", 64'(fault), 64'(r.flt));
                chk("fault_code", 64'(fault_code), 64'(r.code));
                chk("done_cycle", 64'(cyc), 64'(r.at));
            end
        end
        if (mem_req) begin
            if (mq.size() == 0) begin
                chk("unexpected_req", 64'(mem_req), 64'd0);
            end else begin
                chk("req_addr_wdata", {mem_addr, mem_wdata}, {mq[0].a, mq[0].wd});
                chk("req_we_strb", 64'({mem_we, mem_wstrb}), 64'({mq[0].we, mq[0].strb}));
            end
            req_cnt++;
        end else if (req_cnt > 0) begin
            if (mq.size() > 0) begin
                mem_t m;
                m = mq.pop_front();
                chk("req_cycles", 64'(req_cnt), 64'(m.nreq));
            end
            req_cnt = 0;
        end
    end

    task automatic wait_idle();
        int i = 0;
        while (!in_ready && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        chk("idle_bound", 64'(in_ready), 64'd1);
    endtask

    // waits: ack after this many wait cycles (only used when e_code is NONE).
    task automatic run(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int waits, input logic [31:0] rd,
                       input logic [31:0] e_ld, input logic [1:0] e_code,
                       input logic e_we, input logic [3:0] e_strb,
                       input logic [31:0] e_wd);
        int n;
        @(negedge clk);
        in_valid = 1'b1; opcode_reg = opc; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = cyc;
        chk("ready_low_after_accept", 64'(in_ready), 64'd0);
        if (e_code == FLT_NONE) begin
            mq.push_back('{e_we, {a[31:2], 2'b00}, e_strb, e_wd, waits + 1});
            rq.push_back('{e_ld, 1'b0, FLT_NONE, n + 1 + waits});
            repeat (waits) begin @(posedge clk); #1; end
            mem_ack = 1'b1; mem_rdata = rd;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'h0;
        end else if (e_code == FLT_TMO) begin
            mq.push_back('{1'b0, {a[31:2], 2'b00}, 4'b0000, 32'h0, TMO});
            rq.push_back('{32'h0, 1'b1, FLT_TMO, n + TMO});
            repeat (TMO) begin @(posedge clk); #1; end
            chk("tmo_req_dropped", 64'(mem_req), 64'd0);
            chk("tmo_ready_in_done", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            chk("tmo_ready_after", 64'(in_ready), 64'd1);
        end else begin
            rq.push_back('{32'h0, 1'b1, e_code, n});
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode_reg = 7'h0; funct3 = 3'h0;
        addr = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outs", 64'({done, fault, fault_code, mem_req, mem_we, mem_wstrb}), 64'd0);
        chk("rst_data", {load_data, mem_wdata}, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;

        // Loads: width, extension and lane selection.
        run(OPC_LOAD,  F3_W,  32'h1000, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, FLT_NONE, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  F3_B,  32'h1003, 32'h0, 0, 32'h80112233, 32'hFFFFFF80, FLT_NONE, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  F3_BU, 32'h1003, 32'h0, 1, 32'h80112233, 32'h00000080, FLT_NONE, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  F3_HU, 32'h1002, 32'h0, 0, 32'h80112233, 32'h00008011, FLT_NONE, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  F3_H,  32'h1002, 32'h0, 2, 32'h80112233, 32'hFFFF8011, FLT_NONE, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  F3_H,  32'h1000, 32'h0, 0, 32'h80117FFF, 32'h00007FFF, FLT_NONE, 1'b0, 4'b0000, 32'h0);
        // Stores; the sh ack lands on the last counter value, so ack must win.
        run(OPC_STORE, F3_H,  32'h2002, 32'h0000ABCD, 3, 32'h0, 32'h0, FLT_NONE, 1'b1, 4'b1100, 32'hABCDABCD);
        run(OPC_STORE, F3_B,  32'h3001, 32'h123456A5, 1, 32'h0, 32'h0, FLT_NONE, 1'b1, 4'b0010, 32'hA5A5A5A5);
        run(OPC_STORE, F3_W,  32'h3004, 32'hCAFEF00D, 0, 32'h0, 32'h0, FLT_NONE, 1'b1, 4'b1111, 32'hCAFEF00D);
        // Faults: misaligned, illegal, illegal beating misaligned, timeout.
        run(OPC_LOAD,  F3_W,  32'h1001, 32'h0, 0, 32'h0, 32'h0, FLT_MIS, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  F3_H,  32'h1003, 32'h0, 0, 32'h0, 32'h0, FLT_MIS, 1'b0, 4'b0000, 32'h0);
        run(7'b0110011, F3_W, 32'h1000, 32'h0, 0, 32'h0, 32'h0, FLT_ILL, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  3'b011, 32'h1000, 32'h0, 0, 32'h0, 32'h0, FLT_ILL, 1'b0, 4'b0000, 32'h0);
        run(OPC_STORE, F3_HU, 32'h1001, 32'h0, 0, 32'h0, 32'h0, FLT_ILL, 1'b0, 4'b0000, 32'h0);
        run(OPC_LOAD,  F3_W,  32'h4000, 32'h0, 0, 32'h0, 32'h0, FLT_TMO, 1'b0, 4'b0000, 32'h0);

        // Reset in the middle of an access, then a stray ack while idle.
        @(negedge clk);
        in_valid = 1'b1; opcode_reg = OPC_LOAD; funct3 = F3_W; addr = 32'h5000; store_data = 32'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mq.push_back('{1'b0, 32'h5000, 4'b0000, 32'h0, 2});
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_req", 64'(mem_req), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("stray_ack_ready", 64'(in_ready), 64'd1);
        chk("stray_ack_done", 64'(done), 64'd0);
        run(OPC_LOAD,  F3_W,  32'h1000, 32'h0, 2, 32'h11223344, 32'h11223344, FLT_NONE, 1'b0, 4'b0000, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_left", 64'(rq.size()), 64'd0);
        chk("mem_left", 64'(mq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit that consumes the ALU's effective address (ALUResult) for RV32I loads and stores and performs the data-memory transaction. It decodes size from funct3, checks alignment, and generates word-aligned requests with byte strobes. It holds a req/ack handshake to data memory with a timeout, then returns a sign- or zero-extended load result to writeback with a one-cycle done pulse.

Parameters:
TIMEOUT_CYCLES, 255, number of ACCESS cycles without mem_ack before the access aborts with a timeout fault (1..65535)
CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request from execute stage
in_ready  out  1  high only in IDLE; a request is accepted when in_valid && in_ready
opcode_reg  in  7  0000011 = load, 0100011 = store; any other value raises an illegal fault
funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  32  effective address from ALUResult
store_data  in  32  rs2 value
done  out  1  one-cycle pulse when the access completes or faults
load_data  out  32  extended load result, valid with done; 0 for stores and faults
fault  out  1  valid with done
fault_code  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  32  {addr[31:2], 2'b00}
mem_wstrb  out  4  byte enables (0000 for reads)
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  completes the request in the cycle it is sampled high with mem_req

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; in_ready=1; done, fault, mem_req, mem_we = 0; fault_code=00; load_data, mem_addr, mem_wdata = 0; mem_wstrb=0000; counter=0.
- Reset mid-access: mem_req drops at that same edge. No done pulse is produced. A later mem_ack is ignored in IDLE.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, request accepted at edge N. All inputs are registered.
  - Legal and aligned: go to ACCESS with mem_req=1 from cycle N+1.
  - Otherwise: go to DONE with fault set. No mem_req is ever issued.
- Legality and alignment checks:
  - Illegal (10): opcode not load/store, load funct3 in {011,110,111}, or store funct3 >= 011.
  - Misaligned (01): h/hu with addr[0]=1, or w with addr[1:0]!=00.
  - If both apply, illegal takes precedence.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata stay stable until ack.
  - mem_ack high: go to DONE and capture load data that cycle. Zero-wait memory gives done at N+2.
  - Counter increments each ACCESS cycle without ack. When counter reaches TIMEOUT_CYCLES-1 without ack: drop mem_req, go to DONE with fault 11.
  - An ack in the same cycle as the timeout wins (normal completion).
- DONE: done=1 for exactly one cycle, then IDLE. in_ready=0 in ACCESS and DONE, so back-to-back throughput is one access per 3 cycles minimum.
- Store lanes, with off = addr[1:0]:
  - sb: wstrb = 0001<<off; wdata = {4{data[7:0]}}.
  - sh: wstrb = 0011<<off; wdata = {2{data[15:0]}}.
  - sw: wstrb = 1111; wdata = data.
- Loads: shift rdata right by 8*off, then extend.
  - b: sign-extend bit 7. bu: zero-extend.
  - h: sign-extend bit 15. hu: zero-extend.
  - w: pass through.
- load_data holds its value until the next done. Stores return load_data=0.
- in_valid while in_ready=0 is ignored; no queuing. Upstream holds the request.

Decomposition:
- Package lsu_pkg:
  - opcode constants OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011
  - funct3 constants F3_B/H/W/BU/HU
  - state enum {IDLE, ACCESS, DONE}
  - fault_code constants FLT_NONE/MIS/ILL/TMO
- Sub-module lsu_align (combinational): {funct3, off, store_data, rdata} -> {wstrb, wdata, load_ext, misaligned, illegal_size}. The FSM and timeout live in lsu_mem_ctrl.

Test Plan:
- lw addr=0x1000, memory acks the same cycle with rdata=0xDEADBEEF -> mem_addr=0x1000, wstrb=0000, done at N+2, load_data=0xDEADBEEF, fault=0.
- lb addr=0x1003, rdata=0x80112233 -> load_data=0xFFFFFF80; lbu at the same address -> 0x00000080; lhu addr=0x1002 -> 0x00008011.
- sh addr=0x2002, store_data=0x0000ABCD, ack after 3 wait cycles -> mem_we=1, wstrb=1100, wdata=0xABCDABCD held stable for 4 cycles, done one cycle after ack.
- lw addr=0x1001 -> no mem_req, done at N+1 with fault_code=01. opcode=0110011 -> fault_code=10.
- TIMEOUT_CYCLES=4, never ack -> mem_req high for 4 cycles then low, done with fault_code=11, in_ready returns high the following cycle.
- rst_n low during ACCESS, then mem_ack pulse in IDLE -> mem_req=0 after the reset edge, no done, in_ready=1, next request served normally.
